// File: rtl/instr_encoder_loader.sv
// RV32I field-bundle encoder and sequential instruction-memory loader.
// Accepts decoded fields, packs and range-checks them, then writes the word at the next address.
module instr_encoder_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 1024
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load_start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [3:0]                     in_kind,
  input  logic [4:0]                     in_rd,
  input  logic [4:0]                     in_rs1,
  input  logic [4:0]                     in_rs2,
  input  logic [2:0]                     in_funct3,
  input  logic                           in_alt,
  input  logic [31:0]                    in_imm,
  output logic                           imem_we,
  output logic [31:0]                    imem_addr,
  output logic [31:0]                    imem_wdata,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           err_illegal
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    WR   = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    K_CAL_R  = 4'd0,
    K_CAL_I  = 4'd1,
    K_LOAD   = 4'd2,
    K_STORE  = 4'd3,
    K_BRANCH = 4'd4,
    K_JAL    = 4'd5,
    K_JALR   = 4'd6,
    K_LUI    = 4'd7,
    K_AUIPC  = 4'd8
  } kind_t;

  localparam logic [6:0] OP_CAL_R  = 7'b0110011;
  localparam logic [6:0] OP_CAL_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t      state, state_nxt;

  logic [3:0]  kind_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic [2:0]  f3_q;
  logic        alt_q;
  logic [31:0] imm_q;

  logic [31:0] word;
  logic        legal;
  logic        accept;

  logic        imm_i_ok, imm_b_ok, imm_j_ok, shamt_ok, upper_ok;
  logic [6:0]  funct7_alt;

  assign full     = (count == CW'(DEPTH));
  assign in_ready = (state == IDLE) && !full;
  assign accept   = in_valid && in_ready && !load_start;
  // load_start suppresses the strobe combinationally so an aborted WR never writes.
  assign imem_we  = (state == WR) && !load_start;

  // Signed-range checks: a value fits in N signed bits when bits [31:N-1] are all equal.
  assign imm_i_ok   = (imm_q[31:11] == '0) || (imm_q[31:11] == '1);
  assign imm_b_ok   = ((imm_q[31:12] == '0) || (imm_q[31:12] == '1)) && !imm_q[0];
  assign imm_j_ok   = ((imm_q[31:20] == '0) || (imm_q[31:20] == '1)) && !imm_q[0];
  assign shamt_ok   = (imm_q[31:5] == '0);
  assign upper_ok   = (imm_q[11:0] == '0);
  assign funct7_alt = {1'b0, alt_q, 5'b0};

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (kind_q)
      K_CAL_R: begin
        word = {funct7_alt, rs2_q, rs1_q, f3_q, rd_q, OP_CAL_R};
        if (alt_q && (f3_q != 3'b000) && (f3_q != 3'b101)) legal = 1'b0;
      end
      K_CAL_I: begin
        if ((f3_q == 3'b001) || (f3_q == 3'b101)) begin
          word = {funct7_alt, imm_q[4:0], rs1_q, f3_q, rd_q, OP_CAL_I};
          if (!shamt_ok) legal = 1'b0;
        end else begin
          word = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_CAL_I};
          if (!imm_i_ok) legal = 1'b0;
        end
        if (alt_q && (f3_q != 3'b101)) legal = 1'b0;
      end
      K_LOAD: begin
        word = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_LOAD};
        if (!imm_i_ok) legal = 1'b0;
        if ((f3_q == 3'b011) || (f3_q == 3'b110) || (f3_q == 3'b111)) legal = 1'b0;
      end
      K_STORE: begin
        word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], OP_STORE};
        if (!imm_i_ok || (f3_q > 3'b010)) legal = 1'b0;
      end
      K_BRANCH: begin
        word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], OP_BRANCH};
        if (!imm_b_ok || (f3_q == 3'b010) || (f3_q == 3'b011)) legal = 1'b0;
      end
      K_JAL: begin
        word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, OP_JAL};
        if (!imm_j_ok) legal = 1'b0;
      end
      K_JALR: begin
        word = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_JALR};
        if (!imm_i_ok || (f3_q != 3'b000)) legal = 1'b0;
      end
      K_LUI: begin
        word = {imm_q[31:12], rd_q, OP_LUI};
        if (!upper_ok) legal = 1'b0;
      end
      K_AUIPC: begin
        word = {imm_q[31:12], rd_q, OP_AUIPC};
        if (!upper_ok) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ENC;
      ENC:     state_nxt = legal ? WR : IDLE;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (load_start) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      f3_q   <= '0;
      alt_q  <= 1'b0;
      imm_q  <= '0;
    end else if (accept) begin
      kind_q <= in_kind;
      rd_q   <= in_rd;
      rs1_q  <= in_rs1;
      rs2_q  <= in_rs2;
      f3_q   <= in_funct3;
      alt_q  <= in_alt;
      imm_q  <= in_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_addr   <= BASE_ADDR;
      imem_wdata  <= '0;
      count       <= '0;
      err_illegal <= 1'b0;
    end else if (load_start) begin
      imem_addr   <= BASE_ADDR;
      count       <= '0;
      err_illegal <= 1'b0;
    end else begin
      if (state == ENC) begin
        if (legal) imem_wdata  <= word;
        else       err_illegal <= 1'b1;
      end
      if (state == WR) begin
        imem_addr <= imem_addr + 32'd4;
        count     <= count + CW'(1);
      end
    end
  end

endmodule
